uart_rx_frame: RTL

//  Serial UART receiver (8 data bits, 1 stop bit, LSB first) feeding the UART receive buffer.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 20 ++
 rtl/uart_rx_frame.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and baud divisor helper.
// UART_RX_PARITY_EN adds the PARITY receiver state.
package uart_pkg;
   localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
`endif
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      int d;
      d = clk_freq / (baud * oversample);
      return (d < 1) ? 1 : d;
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick generator with synchronous clear for frame alignment.
module uart_baud_tick import uart_pkg::*; #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst_n || clr) cnt <= '0;
      else cnt <= tick ? '0 : cnt + CW'(1);
   end
   assign tick = (cnt == CW'(DIV - 1));
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling 8-bit UART receiver, LSB first, 1 stop bit.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output.
module uart_rx_frame import uart_pkg::*; #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);
   localparam int PW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   rx_state_t state, state_n;
   logic rx_m, rx_s, tick, clr, last, sample, par_bad;
   logic [PW-1:0] phase;
   logic [BW-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
   logic par_bit;
   assign par_bad = ^{shift, par_bit};
`else
   assign par_bad = 1'b0;
`endif
   uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
      .clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick)
   );
   assign clr    = (state == IDLE) && !rx_s;
   // START samples half a bit in; every later sample is one full bit after the previous one
   assign last   = (state == START) ? (phase == PW'(OVERSAMPLE/2 - 1)) : (phase == PW'(OVERSAMPLE - 1));
   assign sample = tick && last;
   assign busy   = (state != IDLE);
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (!rx_s) state_n = START;
         START:     if (sample) state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:      if (sample && bit_cnt == BW'(DATA_BITS - 1)) state_n = PARITY;
         PARITY:    if (sample) state_n = STOP;
`else
         DATA:      if (sample && bit_cnt == BW'(DATA_BITS - 1)) state_n = STOP;
`endif
         STOP:      if (sample) state_n = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         state     <= IDLE;
         phase     <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         {rx_s, rx_m} <= {rx_m, rx};
         state        <= state_n;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err   <= 1'b0;
         if (state == PARITY && sample) par_bit <= rx_s;
`endif
         if (state == IDLE) begin
            phase   <= '0;
            bit_cnt <= '0;
         end else if (tick) begin
            phase <= last ? '0 : phase + PW'(1);
         end
         if (state == DATA && sample) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
         end
         if (state == STOP && sample) begin
            frame_err <= !rx_s;
            rx_valid  <= rx_s && !par_bad;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (rx_s && !par_bad) rx_data <= shift;
         end
      end
   end
endmodule
